// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the CPU datapath and a word-wide
// Avalon-style data RAM port. Byte/half/word requests become word-aligned bus
// cycles with byteenables and lane-replicated write data. Load data is
// extracted from the addressed lanes and sign/zero-extended.
//
// Optional feature macro: MAU_ALIGN_CHECK_EN
//   defined   - misaligned half/word requests skip the bus and respond with rsp_err=1
//   undefined - no checking; low address bits are ignored (forced alignment), rsp_err=0
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// BUS   | avm_read/avm_write asserted, held while avm_waitrequest
// LAT   | read accepted, counting down the fixed read latency
// RESP  | rsp_valid pulse for one cycle
module mem_access_unit #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        LAT  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  lat_cnt;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  off_q;

    logic        misaligned;
    logic [3:0]  be_next;
    logic [31:0] wd_next;
    logic [31:0] load_ext;
    logic [7:0]  lane8;
    logic [15:0] lane16;

    assign req_ready = (state == IDLE);

`ifdef MAU_ALIGN_CHECK_EN
    // Flag half accesses on odd bytes and word accesses off a word boundary.
    always_comb begin
        misaligned = 1'b0;
        if (req_size == 2'b01)
            misaligned = req_addr[0];
        else if (req_size[1])
            misaligned = |req_addr[1:0];
    end
`else
    assign misaligned = 1'b0;
`endif

    // Byte enables and lane-replicated write data for the incoming request.
    always_comb begin
        be_next = 4'b1111;
        wd_next = req_wdata;
        case (req_size)
            2'b00: begin
                be_next = 4'b0001 << req_addr[1:0];
                wd_next = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_next = req_addr[1] ? 4'b1100 : 4'b0011;
                wd_next = {2{req_wdata[15:0]}};
            end
            default: begin
                be_next = 4'b1111;
                wd_next = req_wdata;
            end
        endcase
    end

    // Lane extraction and extension of returning read data, using the latched request shape.
    always_comb begin
        lane8    = avm_readdata[{off_q, 3'b000} +: 8];
        lane16   = avm_readdata[{off_q[1], 4'b0000} +: 16];
        load_ext = avm_readdata;
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & lane8[7]}}, lane8};
            2'b01:   load_ext = {{16{signed_q & lane16[15]}}, lane16};
            default: load_ext = avm_readdata;
        endcase
    end

    // Access sequencer with registered bus and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            lat_cnt        <= 3'd0;
            size_q         <= 2'b00;
            signed_q       <= 1'b0;
            off_q          <= 2'b00;
            avm_address    <= 32'h0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_byteenable <= 4'h0;
            avm_writedata  <= 32'h0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= 32'h0;
            rsp_err        <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        off_q    <= req_addr[1:0];
                        if (misaligned) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                            state     <= RESP;
                        end else begin
                            avm_address    <= {req_addr[31:2], 2'b00};
                            avm_byteenable <= be_next;
                            avm_writedata  <= wd_next;
                            avm_read       <= ~req_write;
                            avm_write      <= req_write;
                            state          <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (!avm_waitrequest) begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        if (avm_write) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= 32'h0;
                            state     <= RESP;
                        end else begin
                            lat_cnt <= 3'(READ_LATENCY);
                            state   <= LAT;
                        end
                    end
                end
                LAT: begin
                    if (lat_cnt == 3'd1) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_ext;
                        state     <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: bench RAM with registered 1-cycle read and
// bench-driven waitrequest; expectations come from a byte-array memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] avm_address, avm_writedata, avm_readdata;
    logic        avm_read, avm_write, avm_waitrequest;
    logic [3:0]  avm_byteenable;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.READ_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .avm_address(avm_address), .avm_read(avm_read),
        .avm_write(avm_write), .avm_byteenable(avm_byteenable),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata)
    );

    // Bench RAM: 64 words, byte-enabled writes, registered read data.
    logic        mem_fill;
    logic [31:0] ram [0:63];

    function automatic logic [31:0] init_word(int i);
        return 32'(32'h9E3779B9 * (i + 1)) ^ 32'h0F0F1234;
    endfunction

    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
            avm_readdata <= 32'h0;
        end else begin
            if (avm_write && !avm_waitrequest)
                for (int b = 0; b < 4; b++)
                    if (avm_byteenable[b]) ram[avm_address[7:2]][8*b +: 8] <= avm_writedata[8*b +: 8];
            if (avm_read && !avm_waitrequest)
                avm_readdata <= ram[avm_address[7:2]];
        end
    end

    // Reference model: flat byte memory.
    logic [7:0] ref_mem [0:255];

    function automatic int nbytes(logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic int base_of(logic [31:0] a, logic [1:0] sz);
        int n = nbytes(sz);
        int lo = int'(a[7:0]);
        return lo - (lo % n);
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] a, logic [1:0] sz, logic sg);
        int n = nbytes(sz);
        int base = base_of(a, sz);
        longint v = 0;
        for (int k = 0; k < n; k++) v += longint'(ref_mem[base + k]) << (8 * k);
        if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int n = nbytes(sz);
        int base = base_of(a, sz);
        for (int k = 0; k < n; k++) ref_mem[base + k] = wd[8*k +: 8];
    endtask

    function automatic logic [3:0] exp_be(logic [31:0] a, logic [1:0] sz);
        int n = nbytes(sz);
        int al = base_of(a, sz) % 4;
        logic [3:0] be = 4'h0;
        for (int k = 0; k < n; k++) be[al + k] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_wd(logic [31:0] wd, logic [1:0] sz);
        int n = nbytes(sz);
        logic [31:0] r = 32'h0;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = wd[8*(j % n) +: 8];
        return r;
    endfunction

    function automatic logic is_misaligned(logic [31:0] a, logic [1:0] sz);
`ifdef MAU_ALIGN_CHECK_EN
        int n = nbytes(sz);
        return (n > 1) && ((int'(a[1:0]) % n) != 0);
`else
        return (a[0] & 1'b0) | (sz[0] & 1'b0);
`endif
    endfunction

    // Observations of one access.
    int          ob_rsp_cyc, ob_rsp_cnt, ob_strobe_cnt;
    logic        ob_unstable, ob_ready_bad, ob_ready_after, ob_accept_ready;
    logic [31:0] ob_rdata, ob_addr, ob_wd;
    logic [3:0]  ob_be;
    logic        ob_err, ob_rd, ob_wr;

    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input int wcyc,
                         input logic b2b);
        int cyc;
        if (!b2b) @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        ob_rsp_cyc = -1; ob_rsp_cnt = 0; ob_strobe_cnt = 0; ob_unstable = 1'b0;
        ob_ready_bad = 1'b0; ob_ready_after = 1'b0; ob_rdata = 32'h0; ob_err = 1'b0;
        ob_addr = 32'h0; ob_be = 4'h0; ob_wd = 32'h0; ob_rd = 1'b0; ob_wr = 1'b0;
        ob_accept_ready = req_ready;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        cyc = 1;
        avm_waitrequest = (cyc <= wcyc);
        forever begin
            @(negedge clk);
            if (cyc == 1) begin
                ob_addr = avm_address; ob_be = avm_byteenable; ob_wd = avm_writedata;
                ob_rd = avm_read; ob_wr = avm_write;
            end
            if (avm_read || avm_write) begin
                ob_strobe_cnt++;
                if (avm_address !== ob_addr || avm_byteenable !== ob_be || avm_writedata !== ob_wd ||
                    avm_read !== ob_rd || avm_write !== ob_wr) ob_unstable = 1'b1;
            end
            if (ob_rsp_cyc < 0 && req_ready) ob_ready_bad = 1'b1;
            if (rsp_valid) begin
                ob_rsp_cnt++;
                if (ob_rsp_cyc < 0) begin
                    ob_rsp_cyc = cyc; ob_rdata = rsp_rdata; ob_err = rsp_err;
                end
            end
            if (ob_rsp_cyc >= 0 && cyc == ob_rsp_cyc + 1) begin
                ob_ready_after = req_ready;
                break;
            end
            if (cyc >= 30) break;
            @(posedge clk); #1;
            cyc++;
            avm_waitrequest = (cyc <= wcyc);
        end
        avm_waitrequest = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; avm_waitrequest = 1'b0;
        mem_fill = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready, avm_read, avm_write, rsp_valid, rsp_err} !== 5'b10000)
            $display("FAIL reset_ctrl: got %b want 10000", {req_ready, avm_read, avm_write, rsp_valid, rsp_err});
        else n_pass++;
        n_checks++;
        if ({avm_address, avm_byteenable, avm_writedata, rsp_rdata} !== 100'h0)
            $display("FAIL reset_data: addr %h be %h wd %h rdata %h want all 0",
                     avm_address, avm_byteenable, avm_writedata, rsp_rdata);
        else n_pass++;
        mem_fill = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b0);
        model_store(32'h10, 2'd2, 32'hDEADBEEF);
        n_checks++;
        if ({ob_wr, ob_rd, ob_addr, ob_be, ob_wd} !== {1'b1, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF})
            $display("FAIL sw_bus: wr %b rd %b addr %h be %h wd %h want 1 0 10 f deadbeef",
                     ob_wr, ob_rd, ob_addr, ob_be, ob_wd);
        else n_pass++;
        n_checks++;
        if (ob_rsp_cyc !== 2) $display("FAIL sw_latency: got %0d want 2", ob_rsp_cyc);
        else n_pass++;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        n_checks++;
        if (ob_rsp_cyc !== 3 || ob_rdata !== 32'hDEADBEEF || ob_err !== 1'b0)
            $display("FAIL lw_basic: cyc %0d rdata %h err %b want 3 deadbeef 0", ob_rsp_cyc, ob_rdata, ob_err);
        else n_pass++;
    endtask

    task automatic test_byte_half();
        logic [31:0] exp [0:5];
        logic [1:0]  szs [0:5];
        logic        sgs [0:5];
        logic [31:0] ads [0:5];
        issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 0, 1'b0);
        model_store(32'h13, 2'd0, 32'hA5);
        n_checks++;
        if (ob_be !== 4'b1000 || ob_wd !== 32'hA5A5A5A5)
            $display("FAIL sb_lanes: be %b wd %h want 1000 a5a5a5a5", ob_be, ob_wd);
        else n_pass++;
        exp[0] = 32'hFFFFFFA5; szs[0] = 2'd0; sgs[0] = 1'b1; ads[0] = 32'h13;
        exp[1] = 32'h000000A5; szs[1] = 2'd0; sgs[1] = 1'b0; ads[1] = 32'h13;
        exp[2] = 32'hA5ADBEEF; szs[2] = 2'd2; sgs[2] = 1'b0; ads[2] = 32'h10;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, szs[i], sgs[i], ads[i], 32'h0, 0, 1'b0);
            n_checks++;
            if (ob_rdata !== exp[i] || ob_rsp_cyc !== 3)
                $display("FAIL load_b%0d: rdata %h cyc %0d want %h 3", i, ob_rdata, ob_rsp_cyc, exp[i]);
            else n_pass++;
        end
        issue(1'b1, 2'd1, 1'b0, 32'h12, 32'h00008001, 0, 1'b0);
        model_store(32'h12, 2'd1, 32'h8001);
        n_checks++;
        if (ob_be !== 4'b1100 || ob_wd !== 32'h80018001)
            $display("FAIL sh_lanes: be %b wd %h want 1100 80018001", ob_be, ob_wd);
        else n_pass++;
        exp[3] = 32'hFFFF8001; szs[3] = 2'd1; sgs[3] = 1'b1; ads[3] = 32'h12;
        exp[4] = 32'h00008001; szs[4] = 2'd1; sgs[4] = 1'b0; ads[4] = 32'h12;
        for (int i = 3; i < 5; i++) begin
            issue(1'b0, szs[i], sgs[i], ads[i], 32'h0, 0, 1'b0);
            n_checks++;
            if (ob_rdata !== exp[i])
                $display("FAIL load_h%0d: rdata %h want %h", i, ob_rdata, exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_waitstate();
        logic [31:0] e;
        e = model_load(32'h10, 2'd2, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 3, 1'b0);
        n_checks++;
        if (ob_strobe_cnt !== 4 || ob_unstable !== 1'b0 || ob_addr !== 32'h10 || ob_rd !== 1'b1)
            $display("FAIL wait_hold: strobes %0d unstable %b addr %h rd %b want 4 0 10 1",
                     ob_strobe_cnt, ob_unstable, ob_addr, ob_rd);
        else n_pass++;
        n_checks++;
        if (ob_rsp_cyc !== 6 || ob_rsp_cnt !== 1 || ob_ready_bad !== 1'b0 || ob_rdata !== e)
            $display("FAIL wait_rsp: cyc %0d cnt %0d readybad %b rdata %h want 6 1 0 %h",
                     ob_rsp_cyc, ob_rsp_cnt, ob_ready_bad, ob_rdata, e);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        logic [31:0] e;
        e = model_load(32'h10, 2'd2, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 0, 1'b0);
`ifdef MAU_ALIGN_CHECK_EN
        n_checks++;
        if (ob_rsp_cyc !== 1 || ob_err !== 1'b1 || ob_rdata !== 32'h0 || ob_strobe_cnt !== 0)
            $display("FAIL misalign_err: cyc %0d err %b rdata %h strobes %0d want 1 1 0 0",
                     ob_rsp_cyc, ob_err, ob_rdata, ob_strobe_cnt);
        else n_pass++;
`else
        n_checks++;
        if (ob_rsp_cyc !== 3 || ob_err !== 1'b0 || ob_rdata !== e || ob_addr !== 32'h10)
            $display("FAIL misalign_forced: cyc %0d err %b rdata %h addr %h want 3 0 %h 10",
                     ob_rsp_cyc, ob_err, ob_rdata, ob_addr, e);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] wd;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (avm_read !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b1)
            $display("FAIL midreset: rd %b rspv %b rdata %h ready %b want 0 0 0 1",
                     avm_read, rsp_valid, rsp_rdata, req_ready);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        wd = $urandom;
        issue(1'b1, 2'd2, 1'b0, 32'h20, wd, 0, 1'b0);
        model_store(32'h20, 2'd2, wd);
        n_checks++;
        if (ob_rsp_cyc !== 2 || ob_wr !== 1'b1 || ob_wd !== wd)
            $display("FAIL post_reset_sw: cyc %0d wr %b wd %h want 2 1 %h", ob_rsp_cyc, ob_wr, ob_wd, wd);
        else n_pass++;
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, 1'b0);
        n_checks++;
        if (ob_rsp_cyc !== 3 || ob_rdata !== wd)
            $display("FAIL post_reset_lw: cyc %0d rdata %h want 3 %h", ob_rsp_cyc, ob_rdata, wd);
        else n_pass++;
    endtask

    task automatic test_random();
        logic        wr, sg, b2b, mis;
        logic [1:0]  sz;
        logic [31:0] a, wd, e_data;
        int          w, e_cyc;
        for (int it = 0; it < 60; it++) begin
            wr = 1'($urandom); sg = 1'($urandom); sz = 2'($urandom);
            a = $urandom; wd = $urandom; w = int'($urandom_range(0, 3));
            b2b = (it > 0) && 1'($urandom);
            mis = is_misaligned(a, sz);
            e_data = (wr || mis) ? 32'h0 : model_load(a, sz, sg);
            e_cyc = mis ? 1 : (wr ? 2 + w : 3 + w);
            issue(wr, sz, sg, a, wd, w, b2b);
            if (wr && !mis) model_store(a, sz, wd);
            n_checks++;
            if (ob_rsp_cyc !== e_cyc || ob_rsp_cnt !== 1 || ob_ready_bad !== 1'b0 ||
                ob_ready_after !== 1'b1 || ob_accept_ready !== 1'b1)
                $display("FAIL rnd%0d_timing: cyc %0d cnt %0d rdybad %b rdyafter %b acc %b want %0d 1 0 1 1",
                         it, ob_rsp_cyc, ob_rsp_cnt, ob_ready_bad, ob_ready_after, ob_accept_ready, e_cyc);
            else n_pass++;
            n_checks++;
            if (ob_rdata !== e_data || ob_err !== mis)
                $display("FAIL rnd%0d_data: rdata %h err %b want %h %b", it, ob_rdata, ob_err, e_data, mis);
            else n_pass++;
            if (!mis) begin
                n_checks++;
                if (ob_addr !== (a & ~32'd3) || ob_be !== exp_be(a, sz) || ob_wr !== wr || ob_rd !== !wr ||
                    (wr && ob_wd !== exp_wd(wd, sz)) || ob_strobe_cnt !== w + 1 || ob_unstable !== 1'b0)
                    $display("FAIL rnd%0d_bus: addr %h be %b wd %h wr %b rd %b strobes %0d unst %b want %h %b %h %b %0d",
                             it, ob_addr, ob_be, ob_wd, ob_wr, ob_rd, ob_strobe_cnt, ob_unstable,
                             a & ~32'd3, exp_be(a, sz), exp_wd(wd, sz), wr, w + 1);
                else n_pass++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            logic [31:0] w;
            w = init_word(i);
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
        test_reset();
        test_word();
        test_byte_half();
        test_waitstate();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d", n_checks, n_pass);
        $fatal(1);
    end

endmodule
